// File: rtl/snn_pkg.sv
// Shared types, constants and helpers for the rate-to-spike encoder slice.
// Holds the 16-bit rate type, the LFSR polynomial and the per-lane seed function.
package snn_pkg;

   localparam int RATE_W = 16;

   typedef logic [RATE_W-1:0] rate_t;

   localparam rate_t LFSR_TAPS = 16'hB400;
   localparam rate_t SEED_BASE = 16'hACE1;
   localparam rate_t SEED_STEP = 16'h9E37;

   typedef enum logic [0:0] {
      ENC_SEED = 1'b0,
      ENC_RUN  = 1'b1
   } enc_state_e;

   // Distinct non-zero start point per lane; an all-zero Galois LFSR would lock up.
   function automatic rate_t enc_seed(input int i);
      logic [31:0] prod;
      rate_t       s;
      prod = 32'(i) * 32'(SEED_STEP);
      s    = SEED_BASE ^ prod[RATE_W-1:0];
      return (s == '0) ? rate_t'(1) : s;
   endfunction

   function automatic rate_t lfsr_step(input rate_t l);
      return {1'b0, l[RATE_W-1:1]} ^ (l[0] ? LFSR_TAPS : rate_t'(0));
   endfunction

endpackage

// File: rtl/spike_enc_lane.sv
// One encoder lane: free-running Galois LFSR compared against the channel rate,
// with a refractory down-counter that silences the lane after each spike.
module spike_enc_lane
   import snn_pkg::*;
#(
   parameter int REFRAC_TICKS = 2
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  seed_load,
   input  rate_t seed_val,
   input  logic  tick,
   input  logic  run,
   input  rate_t rate,
   output logic  spike
);

   localparam int REFRAC_W = $clog2(REFRAC_TICKS + 2);

   rate_t               lfsr_reg;
   rate_t               lfsr_next;
   logic [REFRAC_W-1:0] refrac_reg;
   logic [REFRAC_W-1:0] refrac_next;
   logic                spike_reg;
   logic                spike_next;
   logic                fire;

   assign fire = (refrac_reg == '0) && (lfsr_reg <= rate);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr_reg   <= rate_t'(1);
         refrac_reg <= '0;
         spike_reg  <= 1'b0;
      end else begin
         lfsr_reg   <= lfsr_next;
         refrac_reg <= refrac_next;
         spike_reg  <= spike_next;
      end
   end

   always_comb begin
      lfsr_next   = lfsr_reg;
      refrac_next = refrac_reg;
      spike_next  = spike_reg;
      if (seed_load) begin
         lfsr_next   = seed_val;
         refrac_next = '0;
         spike_next  = 1'b0;
      end else if (tick) begin
         if (run) begin
            spike_next = fire;
            lfsr_next  = lfsr_step(lfsr_reg);
            if (fire)
               refrac_next = REFRAC_W'(REFRAC_TICKS);
            else if (refrac_reg != '0)
               refrac_next = refrac_reg - 1'b1;
         end else begin
            // Stopped: output silent, sequence position and refractory state held.
            spike_next = 1'b0;
         end
      end
   end

   assign spike = spike_reg;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-to-spike encoder: per-channel rate register file driving N Bernoulli spike lanes.
// Optional spike counter enabled by defining SPIKE_ENC_CNT_EN.
module spike_rate_encoder
   import snn_pkg::*;
#(
   parameter int N_NEURON     = 64,
   parameter int REFRAC_TICKS = 2
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        clk_en,
   input  logic                                        run_i,
   input  logic                                        wr_valid_i,
   output logic                                        wr_ready_o,
   input  logic [((N_NEURON > 1) ? $clog2(N_NEURON) : 1)-1:0] wr_addr_i,
   input  logic [RATE_W-1:0]                           wr_rate_i,
   output logic                                        wr_err_o,
   output logic [N_NEURON-1:0]                         spike_o,
   output logic                                        busy_o,
   output logic [31:0]                                 dbg_spike_cnt_o
);

   localparam int ADDR_W = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
   localparam logic [ADDR_W:0]   ADDR_LIM = (ADDR_W + 1)'(N_NEURON);
   localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_NEURON - 1);

   enc_state_e        state_reg;
   enc_state_e        state_next;
   logic [ADDR_W-1:0] seed_idx_reg;
   logic [ADDR_W-1:0] seed_idx_next;
   logic              seeding;
   logic              tick;
   logic              wr_accept;
   logic              addr_ok;
   logic              err_reg;
   rate_t             rate_reg [N_NEURON];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ENC_SEED;
         seed_idx_reg <= '0;
      end else begin
         state_reg    <= state_next;
         seed_idx_reg <= seed_idx_next;
      end
   end

   // Seeding ignores clk_en so the array is ready a fixed N cycles after reset.
   always_comb begin
      state_next    = state_reg;
      seed_idx_next = seed_idx_reg;
      case (state_reg)
         ENC_SEED: begin
            if (seed_idx_reg == IDX_LAST) begin
               state_next    = ENC_RUN;
               seed_idx_next = '0;
            end else begin
               seed_idx_next = seed_idx_reg + 1'b1;
            end
         end
         ENC_RUN:  state_next = ENC_RUN;
         default:  state_next = ENC_SEED;
      endcase
   end

   always_comb begin
      seeding    = 1'b0;
      busy_o     = 1'b0;
      wr_ready_o = 1'b0;
      case (state_reg)
         ENC_SEED: begin
            seeding = 1'b1;
            busy_o  = 1'b1;
         end
         ENC_RUN:  wr_ready_o = 1'b1;
         default:  busy_o     = 1'b1;
      endcase
   end

   assign tick      = clk_en && (state_reg == ENC_RUN);
   assign wr_accept = wr_valid_i && wr_ready_o;
   assign addr_ok   = ({1'b0, wr_addr_i} < ADDR_LIM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_reg <= 1'b0;
      else
         err_reg <= wr_accept && !addr_ok;
   end

   assign wr_err_o = err_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N_NEURON; gi++) begin : g_lane
         // Lanes read rate_reg before this edge's write lands, so a same-cycle
         // write only affects the following tick.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               rate_reg[gi] <= '0;
            else if (wr_accept && addr_ok && (wr_addr_i == ADDR_W'(gi)))
               rate_reg[gi] <= wr_rate_i;
         end

         spike_enc_lane #(
            .REFRAC_TICKS (REFRAC_TICKS)
         ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .seed_load (seeding && (seed_idx_reg == ADDR_W'(gi))),
            .seed_val  (enc_seed(gi)),
            .tick      (tick),
            .run       (run_i),
            .rate      (rate_reg[gi]),
            .spike     (spike_o[gi])
         );
      end
   endgenerate

`ifdef SPIKE_ENC_CNT_EN
   localparam int POP_W = $clog2(N_NEURON + 1);

   logic             tick_run_reg;
   logic [POP_W-1:0] pop_cnt;
   logic [32:0]      cnt_sum;
   logic [31:0]      cnt_reg;
   logic [31:0]      cnt_next;

   // Counts the registered vector one cycle after the tick that produced it.
   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < N_NEURON; i++)
         pop_cnt = pop_cnt + POP_W'(spike_o[i]);
      cnt_sum  = {1'b0, cnt_reg} + 33'(pop_cnt);
      cnt_next = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_run_reg <= 1'b0;
         cnt_reg      <= '0;
      end else begin
         tick_run_reg <= tick && run_i;
         if (tick_run_reg)
            cnt_reg <= cnt_next;
      end
   end

   assign dbg_spike_cnt_o = cnt_reg;
`else
   assign dbg_spike_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Bench for spike_rate_encoder: scoreboarded 64-lane instance plus a 12-lane
// no-refractory instance for full-period rate accuracy and out-of-range writes.
module tb_spike_rate_encoder;

   localparam int CLK_P = 10;

   logic clk = 1'b0;
   always #(CLK_P / 2) clk = ~clk;

   int total = 0;
   int bad   = 0;

   // ---------------- instance A: N=64, REFRAC=2 ----------------
   logic        a_rst = 1'b1;
   logic        a_en = 1'b0, a_run = 1'b0, a_wv = 1'b0;
   logic [5:0]  a_addr = '0;
   logic [15:0] a_rate = '0;
   logic        a_ready, a_err, a_busy;
   logic [63:0] a_spike;
   logic [31:0] a_cnt;

   spike_rate_encoder #(.N_NEURON(64), .REFRAC_TICKS(2)) dut_a (
      .clk             (clk),
      .rst             (a_rst),
      .clk_en          (a_en),
      .run_i           (a_run),
      .wr_valid_i      (a_wv),
      .wr_ready_o      (a_ready),
      .wr_addr_i       (a_addr),
      .wr_rate_i       (a_rate),
      .wr_err_o        (a_err),
      .spike_o         (a_spike),
      .busy_o          (a_busy),
      .dbg_spike_cnt_o (a_cnt)
   );

   // ---------------- instance B: N=12, REFRAC=0 ----------------
   logic        b_rst = 1'b1;
   logic        b_en = 1'b0, b_run = 1'b0, b_wv = 1'b0;
   logic [3:0]  b_addr = '0;
   logic [15:0] b_rate = '0;
   logic        b_ready, b_err, b_busy;
   logic [11:0] b_spike;
   logic [31:0] b_cnt;

   spike_rate_encoder #(.N_NEURON(12), .REFRAC_TICKS(0)) dut_b (
      .clk             (clk),
      .rst             (b_rst),
      .clk_en          (b_en),
      .run_i           (b_run),
      .wr_valid_i      (b_wv),
      .wr_ready_o      (b_ready),
      .wr_addr_i       (b_addr),
      .wr_rate_i       (b_rate),
      .wr_err_o        (b_err),
      .spike_o         (b_spike),
      .busy_o          (b_busy),
      .dbg_spike_cnt_o (b_cnt)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // ---------------- reference model for instance A ----------------
   typedef struct packed {
      logic [63:0] spk;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] ma_lfsr [64];
   logic [1:0]  ma_ref  [64];
   logic [15:0] ma_rate [64];
   logic [63:0] ma_spk;
   int          ma_cnt;

   function automatic logic [15:0] tb_seed(input int i);
      logic [31:0] p;
      logic [15:0] s;
      p = i * 32'h9E37;
      s = 16'hACE1 ^ p[15:0];
      if (s == 16'h0000) s = 16'h0001;
      return s;
   endfunction

   function automatic logic [15:0] tb_lfsr(input logic [15:0] l);
      logic [15:0] n;
      n = l >> 1;
      if (l[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   function automatic logic [31:0] exp_cnt(input int c);
`ifdef SPIKE_ENC_CNT_EN
      return 32'(c);
`else
      return 32'(c) & 32'd0;
`endif
   endfunction

   // One clock of instance A: drive, advance the model, queue expectation, compare.
   task automatic step_a(input logic en, input logic run, input logic wv,
                         input logic [5:0] addr, input logic [15:0] rate);
      exp_t e;
      logic f;
      a_en = en; a_run = run; a_wv = wv; a_addr = addr; a_rate = rate;
      if (en) begin
         if (run) begin
            for (int i = 0; i < 64; i++) begin
               f = (ma_ref[i] == 2'd0) && (ma_lfsr[i] <= ma_rate[i]);
               ma_spk[i] = f;
               if (f) ma_ref[i] = 2'd2;
               else if (ma_ref[i] != 2'd0) ma_ref[i] = 2'(ma_ref[i] - 2'd1);
               ma_lfsr[i] = tb_lfsr(ma_lfsr[i]);
            end
            ma_cnt += $countones(ma_spk);
         end else begin
            ma_spk = '0;
         end
      end
      if (wv) ma_rate[addr] = rate;
      e.spk = ma_spk;
      e.err = 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      check_eq("a_spike_vec", a_spike, e.spk);
      check_eq("a_err", a_err, e.err);
   endtask

   task automatic write_a(input logic [5:0] addr, input logic [15:0] rate);
      step_a(1'b0, 1'b0, 1'b1, addr, rate);
      $display("[a] write ch%0d rate=%04h", addr, rate);
   endtask

   task automatic reset_seed_a();
      a_en = 1'b0; a_run = 1'b0; a_wv = 1'b0; a_rst = 1'b1;
      #1;
      check_eq("a_rst_spike", a_spike, 64'd0);
      check_eq("a_rst_ready", a_ready, 1'b0);
      check_eq("a_rst_busy", a_busy, 1'b1);
      check_eq("a_rst_err", a_err, 1'b0);
      for (int i = 0; i < 64; i++) begin
         ma_lfsr[i] = tb_seed(i);
         ma_ref[i]  = 2'd0;
         ma_rate[i] = 16'd0;
      end
      ma_spk = '0;
      ma_cnt = 0;
      @(posedge clk); @(posedge clk); #1;
      a_rst = 1'b0;
      a_en  = 1'b1;
      check_eq("a_seed_busy0", a_busy, 1'b1);
      for (int k = 1; k <= 64; k++) begin
         // A write offered during seeding must be ignored.
         a_wv = (k == 10); a_addr = 6'd7; a_rate = 16'hFFFF;
         @(posedge clk); #1;
         check_eq("a_seed_busy", a_busy, (k < 64));
         check_eq("a_seed_ready", a_ready, (k == 64));
      end
      a_wv = 1'b0; a_en = 1'b0;
      check_eq("a_seed_spike", a_spike, 64'd0);
      check_eq("a_seed_cnt", a_cnt, 32'd0);
      $display("[a] reset+seed done, busy for 64 cycles");
   endtask

   task automatic seq_a();
      int c3, loud, c0, patbad;
      reset_seed_a();

      // Rate 0 everywhere: silence.
      write_a(6'd3, 16'd0);
      c3 = 0; loud = 0;
      for (int t = 0; t < 10000; t++) begin
         step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
         c3   += int'(a_spike[3]);
         loud += int'(|a_spike);
      end
      check_eq("t2_ch3_spikes", 64'(c3), 64'd0);
      check_eq("t2_any_spikes", 64'(loud), 64'd0);
      $display("[a] T2 10000 ticks ch3=%0d spikes", c3);

      // Saturated ch0 plus random background lanes.
      write_a(6'd0, 16'hFFFF);
      for (int ch = 8; ch < 24; ch++)
         write_a(6'(ch), 16'($urandom_range(0, 65535)));
      c0 = 0; patbad = 0;
      for (int t = 0; t < 3000; t++) begin
         step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
         c0 += int'(a_spike[0]);
         if (a_spike[0] !== ((t % 3) == 0)) patbad++;
      end
      check_eq("t4_ch0_count", 64'(c0), 64'd1000);
      check_eq("t4_ch0_pattern", 64'(patbad), 64'd0);
      step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
      check_eq("t4_dbg_cnt", a_cnt, exp_cnt(ma_cnt));
      $display("[a] T4 3000 ticks ch0=%0d spikes", c0);

      // Freeze with clk_en low, stop with run_i low, then resume.
      begin
         logic [63:0] snap;
         for (int t = 0; t < 100; t++) step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
         snap = a_spike;
         for (int t = 0; t < 20; t++) step_a(1'b0, 1'b1, 1'b0, 6'd0, 16'd0);
         check_eq("t5_hold", a_spike, snap);
         for (int t = 0; t < 5; t++) step_a(1'b1, 1'b0, 1'b0, 6'd0, 16'd0);
         check_eq("t5_stopped", a_spike, 64'd0);
         for (int t = 0; t < 100; t++) step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
         $display("[a] T5 freeze/stop/resume done");
      end

      // Write coinciding with a tick on the same lane.
      step_a(1'b1, 1'b1, 1'b1, 6'd7, 16'hFFFF);
      check_eq("t6_old_rate", a_spike[7], 1'b0);
      step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
      check_eq("t6_new_rate", a_spike[7], 1'b1);
      $display("[a] T6 ch7 same-cycle write, spike=%0b then %0b", 1'b0, a_spike[7]);

      // Reset mid-run: full reseed, rates cleared, sequences restart.
      reset_seed_a();
      for (int t = 0; t < 20; t++) step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
      check_eq("rst_rates_clear", a_spike, 64'd0);
      write_a(6'd9, 16'h8000);
      for (int t = 0; t < 50; t++) step_a(1'b1, 1'b1, 1'b0, 6'd0, 16'd0);
      step_a(1'b0, 1'b0, 1'b0, 6'd0, 16'd0);
      check_eq("rst_dbg_cnt", a_cnt, exp_cnt(ma_cnt));
      $display("[a] reseed sequence check done");
   endtask

   task automatic seq_b();
      int c5, other;
      b_rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      b_rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         check_eq("b_seed_busy", b_busy, (k < 12));
      end
      check_eq("b_ready", b_ready, 1'b1);

      b_wv = 1'b1; b_addr = 4'd12; b_rate = 16'hFFFF;
      @(posedge clk); #1;
      b_wv = 1'b0;
      check_eq("b_err_pulse12", b_err, 1'b1);
      @(posedge clk); #1;
      check_eq("b_err_clear12", b_err, 1'b0);
      $display("[b] write addr 12 -> err pulse");

      b_wv = 1'b1; b_addr = 4'd15; b_rate = 16'hFFFF;
      @(posedge clk); #1;
      b_wv = 1'b0;
      check_eq("b_err_pulse15", b_err, 1'b1);
      $display("[b] write addr 15 -> err pulse");

      b_wv = 1'b1; b_addr = 4'd5; b_rate = 16'd4096;
      @(posedge clk); #1;
      b_wv = 1'b0;
      check_eq("b_err_valid", b_err, 1'b0);
      $display("[b] write ch5 rate=1000");

      b_en = 1'b1; b_run = 1'b1;
      c5 = 0; other = 0;
      for (int t = 0; t < 65535; t++) begin
         @(posedge clk); #1;
         c5    += int'(b_spike[5]);
         other += $countones(b_spike & 12'hFDF);
      end
      b_en = 1'b0; b_run = 1'b0;
      @(posedge clk); #1;
      check_eq("t3_ch5_count", 64'(c5), 64'd4096);
      check_eq("t3_other_silent", 64'(other), 64'd0);
      check_eq("t3_dbg_cnt", b_cnt, exp_cnt(4096));
      $display("[b] T3 65535 ticks ch5=%0d spikes", c5);
   endtask

   initial begin
      fork
         seq_a();
         seq_b();
      join
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #(CLK_P * 150000);
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
